// File: rtl/bus_master_arb_pkg.sv
// Shared definitions for the two-master arbiter: grant states, read-select codes
// and the slave address map that the address decoder also uses.
package bus_master_arb_pkg;

    typedef enum logic {
        StGnt0 = 1'b0,
        StGnt1 = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SelNone = 2'd0,
        SelS0   = 2'd1,
        SelS1   = 2'd2
    } rd_sel_e;

    localparam logic [7:0] S0_BASE  = 8'h00;
    localparam logic [7:0] S0_LIMIT = 8'h20;
    localparam logic [7:0] S1_BASE  = 8'h30;
    localparam logic [7:0] S1_LIMIT = 8'h40;

    // Half-open range test [base, limit); the subtraction keeps it valid for any base.
    function automatic logic in_range(logic [7:0] addr, logic [7:0] base, logic [7:0] limit);
        return 8'(addr - base) < 8'(limit - base);
    endfunction

endpackage

// File: rtl/bus_rd_mux.sv
// Read-return path: registers which slave answered the granted read and who owned it,
// then steers that slave's data back to the masters one cycle later.
module bus_rd_mux
    import bus_master_arb_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_rd_en,
    input  logic          i_s0_sel,
    input  logic          i_s1_sel,
    input  logic          i_owner,
    input  logic [DW-1:0] i_s0_dout,
    input  logic [DW-1:0] i_s1_dout,
    output logic [DW-1:0] o_din,
    output logic          o_din_valid,
    output logic          o_din_id
);

    rd_sel_e r_sel;
    rd_sel_e w_sel_next;
    logic    r_id;

    // S0 takes priority if the decoder ever raises both selects.
    always_comb begin
        w_sel_next = SelNone;
        if (i_rd_en) begin
            if (i_s0_sel) begin
                w_sel_next = SelS0;
            end else if (i_s1_sel) begin
                w_sel_next = SelS1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel <= SelNone;
            r_id  <= 1'b0;
        end else begin
            r_sel <= w_sel_next;
            r_id  <= i_owner;
        end
    end

    always_comb begin
        o_din = '0;
        unique case (r_sel)
            SelS0:   o_din = i_s0_dout;
            SelS1:   o_din = i_s1_dout;
            default: o_din = '0;
        endcase
    end

    assign o_din_valid = (r_sel != SelNone);
    assign o_din_id    = r_id;

endmodule

// File: rtl/bus_master_arb.sv
// Two-master bus arbiter with bounded hold time; forwards the owner's request to the
// shared slave bus and returns tagged read data one cycle later.
module bus_master_arb
    import bus_master_arb_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          M0_req,
    input  logic          M0_wr,
    input  logic [AW-1:0] M0_addr,
    input  logic [DW-1:0] M0_dout,
    input  logic          M1_req,
    input  logic          M1_wr,
    input  logic [AW-1:0] M1_addr,
    input  logic [DW-1:0] M1_dout,
    input  logic          S0_sel,
    input  logic          S1_sel,
    input  logic [DW-1:0] S0_dout,
    input  logic [DW-1:0] S1_dout,
    output logic          M0_grant,
    output logic          M1_grant,
    output logic [AW-1:0] S_addr,
    output logic          S_wr,
    output logic [DW-1:0] S_din,
    output logic [DW-1:0] M_din,
    output logic          M_din_valid,
    output logic          M_din_id
);

    localparam int unsigned    HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

    state_e          r_state;
    state_e          w_state_next;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_next;
    logic            w_gnt1;
    logic            w_owner_req;
    logic            w_owner_wr;
    logic            w_other_req;
    logic            w_hold_hit;

    assign w_gnt1      = (r_state == StGnt1);
    assign w_owner_req = w_gnt1 ? M1_req : M0_req;
    assign w_owner_wr  = w_gnt1 ? M1_wr : M0_wr;
    assign w_other_req = w_gnt1 ? M0_req : M1_req;
    assign w_hold_hit  = (MAX_HOLD > 0) && (r_hold == HOLD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StGnt0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
        end
    end

    // With no requests at all the bus stays parked on the current owner.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StGnt0: if (M1_req && (!M0_req || w_hold_hit)) w_state_next = StGnt1;
            StGnt1: if (M0_req && (!M1_req || w_hold_hit)) w_state_next = StGnt0;
        endcase
    end

    always_comb begin
        w_hold_next = '0;
        if ((w_state_next == r_state) && w_owner_req && w_other_req) begin
            w_hold_next = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
        end
    end

    assign M0_grant = !w_gnt1;
    assign M1_grant = w_gnt1;
    assign S_addr   = w_gnt1 ? M1_addr : M0_addr;
    assign S_din    = w_gnt1 ? M1_dout : M0_dout;
    assign S_wr     = w_owner_req & w_owner_wr;

    bus_rd_mux #(
        .DW (DW)
    ) u_rd_mux (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_rd_en     (w_owner_req & ~w_owner_wr),
        .i_s0_sel    (S0_sel),
        .i_s1_sel    (S1_sel),
        .i_owner     (w_gnt1),
        .i_s0_dout   (S0_dout),
        .i_s1_dout   (S1_dout),
        .o_din       (M_din),
        .o_din_valid (M_din_valid),
        .o_din_id    (M_din_id)
    );

endmodule

// File: tb/tb_bus_master_arb.sv
// Bench for bus_master_arb: vector table plus hand sequences, with a decoder and two
// slave models around the DUT and a queue holding the expected read return.
module tb_bus_master_arb;
    import bus_master_arb_pkg::*;

    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_HOLD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          M0_req, M0_wr, M1_req, M1_wr;
    logic [AW-1:0] M0_addr, M1_addr;
    logic [DW-1:0] M0_dout, M1_dout;
    logic          S0_sel, S1_sel;
    logic [DW-1:0] S0_dout, S1_dout;
    logic          M0_grant, M1_grant, S_wr, M_din_valid, M_din_id;
    logic [AW-1:0] S_addr;
    logic [DW-1:0] S_din, M_din;
    logic          force_both = 1'b0;
    logic [DW-1:0] mem [32];

    typedef struct {
        logic          m0_req, m0_wr;
        logic [AW-1:0] m0_addr;
        logic [DW-1:0] m0_dout;
        logic          m1_req, m1_wr;
        logic [AW-1:0] m1_addr;
        logic [DW-1:0] m1_dout;
        logic          e_g0;
        logic [AW-1:0] e_addr;
        logic          e_wr;
        logic [DW-1:0] e_sdin;
        logic          e_v;
        logic [DW-1:0] e_din;
        logic          e_id;
    } vec_t;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic          id;
    } rd_exp_t;

    vec_t    vecs [18];
    rd_exp_t q [$];
    int      n_cmp = 0;
    int      n_bad = 0;

    always #5 clk = ~clk;

    bus_master_arb #(
        .AW       (AW),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .M0_req      (M0_req),
        .M0_wr       (M0_wr),
        .M0_addr     (M0_addr),
        .M0_dout     (M0_dout),
        .M1_req      (M1_req),
        .M1_wr       (M1_wr),
        .M1_addr     (M1_addr),
        .M1_dout     (M1_dout),
        .S0_sel      (S0_sel),
        .S1_sel      (S1_sel),
        .S0_dout     (S0_dout),
        .S1_dout     (S1_dout),
        .M0_grant    (M0_grant),
        .M1_grant    (M1_grant),
        .S_addr      (S_addr),
        .S_wr        (S_wr),
        .S_din       (S_din),
        .M_din       (M_din),
        .M_din_valid (M_din_valid),
        .M_din_id    (M_din_id)
    );

    // Decoder model; force_both injects the illegal double select.
    assign S0_sel = force_both | in_range(S_addr, S0_BASE, S0_LIMIT);
    assign S1_sel = in_range(S_addr, S1_BASE, S1_LIMIT);

    // Slave0: 32-word memory, registered read. Slave1: returns 5 + low address nibble.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
            S0_dout <= '0;
            S1_dout <= '0;
        end else begin
            if (S_wr && S0_sel) mem[S_addr[4:0]] <= S_din;
            S0_dout <= mem[S_addr[4:0]];
            S1_dout <= 32'd5 + {28'd0, S_addr[3:0]};
        end
    end

    function automatic vec_t mk(logic m0r, logic m0w, logic [7:0] m0a, logic [31:0] m0d,
                                logic m1r, logic m1w, logic [7:0] m1a, logic [31:0] m1d,
                                logic eg0, logic [7:0] ea, logic ew, logic [31:0] ed,
                                logic ev, logic [31:0] edin, logic eid);
        vec_t v;
        v.m0_req = m0r; v.m0_wr = m0w; v.m0_addr = m0a; v.m0_dout = m0d;
        v.m1_req = m1r; v.m1_wr = m1w; v.m1_addr = m1a; v.m1_dout = m1d;
        v.e_g0 = eg0; v.e_addr = ea; v.e_wr = ew; v.e_sdin = ed;
        v.e_v = ev; v.e_din = edin; v.e_id = eid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_rd(input string tag);
        rd_exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got valid=%b expected an entry", tag, M_din_valid);
        end else begin
            e = q.pop_front();
            chk({tag, ".m_din_valid"}, 32'(M_din_valid), 32'(e.v));
            chk({tag, ".m_din"}, M_din, e.d);
            chk({tag, ".m_din_id"}, 32'(M_din_id), 32'(e.id));
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        M0_req = v.m0_req; M0_wr = v.m0_wr; M0_addr = v.m0_addr; M0_dout = v.m0_dout;
        M1_req = v.m1_req; M1_wr = v.m1_wr; M1_addr = v.m1_addr; M1_dout = v.m1_dout;
        #1;
        chk({tag, ".m0_grant"}, 32'(M0_grant), 32'(v.e_g0));
        chk({tag, ".m1_grant"}, 32'(M1_grant), 32'(!v.e_g0));
        chk({tag, ".s_addr"}, 32'(S_addr), 32'(v.e_addr));
        chk({tag, ".s_wr"}, 32'(S_wr), 32'(v.e_wr));
        chk({tag, ".s_din"}, S_din, v.e_sdin);
        check_rd(tag);
        q.push_back('{v: v.e_v, d: v.e_din, id: v.e_id});
    endtask

    initial begin
        vecs[0]  = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        1,8'h00,0,32'h0,        0,32'h0,0);
        vecs[1]  = mk(0,0,8'h10,32'h55,       0,0,8'h31,32'h0,        1,8'h10,0,32'h55,       0,32'h0,0);
        vecs[2]  = mk(1,1,8'h05,32'hDEADBEEF, 0,0,8'h00,32'h0,        1,8'h05,1,32'hDEADBEEF, 0,32'h0,0);
        vecs[3]  = mk(1,0,8'h05,32'h0,        0,0,8'h00,32'h0,        1,8'h05,0,32'h0,        1,32'hDEADBEEF,0);
        vecs[4]  = mk(1,1,8'h06,32'h12345678, 0,0,8'h00,32'h0,        1,8'h06,1,32'h12345678, 0,32'h0,0);
        vecs[5]  = mk(1,0,8'h06,32'h0,        0,0,8'h00,32'h0,        1,8'h06,0,32'h0,        1,32'h12345678,0);
        vecs[6]  = mk(1,0,8'h25,32'h0,        0,0,8'h00,32'h0,        1,8'h25,0,32'h0,        0,32'h0,0);
        vecs[7]  = mk(0,0,8'h05,32'h0,        1,0,8'h32,32'h0,        1,8'h05,0,32'h0,        0,32'h0,0);
        vecs[8]  = mk(0,0,8'h05,32'h0,        1,0,8'h32,32'h0,        0,8'h32,0,32'h0,        1,32'h7,1);
        vecs[9]  = mk(0,0,8'h05,32'h0,        1,0,8'h25,32'h0,        0,8'h25,0,32'h0,        0,32'h0,1);
        vecs[10] = mk(0,0,8'h05,32'h0,        1,1,8'h33,32'hAAAA5555, 0,8'h33,1,32'hAAAA5555, 0,32'h0,1);
        vecs[11] = mk(0,0,8'h05,32'h0,        1,0,8'h0A,32'h0,        0,8'h0A,0,32'h0,        1,32'hC0DE000A,1);
        vecs[12] = mk(1,0,8'h05,32'h0,        0,0,8'h0A,32'h0,        0,8'h0A,0,32'h0,        0,32'h0,1);
        vecs[13] = mk(1,0,8'h05,32'h0,        0,0,8'h0A,32'h0,        1,8'h05,0,32'h0,        1,32'hDEADBEEF,0);
        vecs[14] = mk(1,1,8'h07,32'h0BADF00D, 0,1,8'h3F,32'hFFFFFFFF, 1,8'h07,1,32'h0BADF00D, 0,32'h0,0);
        vecs[15] = mk(1,0,8'h07,32'h0,        0,0,8'h3F,32'h0,        1,8'h07,0,32'h0,        1,32'h0BADF00D,0);
        vecs[16] = mk(1,0,8'h3F,32'h0,        0,0,8'h00,32'h0,        1,8'h3F,0,32'h0,        1,32'h14,0);
        vecs[17] = mk(0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        1,8'h00,0,32'h0,        0,32'h0,0);

        reset_n = 1'b0;
        M0_req = 0; M0_wr = 0; M0_addr = '0; M0_dout = '0;
        M1_req = 0; M1_wr = 0; M1_addr = '0; M1_dout = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        q.push_back('{v: 1'b0, d: '0, id: 1'b0});

        for (int i = 0; i < 18; i++) step($sformatf("vec%0d", i), vecs[i]);

        // Both masters reading: ownership alternates every MAX_HOLD cycles.
        for (int k = 0; k < 12; k++) begin
            logic g0;
            g0 = ((k / 4) % 2) == 0;
            step($sformatf("hold%0d", k),
                 mk(1,0,8'h01,32'h11111111, 1,0,8'h31,32'h22222222,
                    g0, g0 ? 8'h01 : 8'h31, 0, g0 ? 32'h11111111 : 32'h22222222,
                    1, g0 ? 32'hC0DE0001 : 32'h6, !g0));
        end
        step("hold12", mk(1,0,8'h01,32'h11111111, 1,0,8'h31,32'h22222222,
                          0,8'h31,0,32'h22222222, 1,32'h6,1));

        // Pending M1 read data visible, then reset drops it without a clock edge.
        @(negedge clk);
        #1;
        check_rd("pend");
        reset_n = 1'b0;
        #1;
        chk("rst.m0_grant", 32'(M0_grant), 32'd1);
        chk("rst.m1_grant", 32'(M1_grant), 32'd0);
        chk("rst.m_din_valid", 32'(M_din_valid), 32'd0);
        chk("rst.m_din", M_din, 32'h0);
        chk("rst.m_din_id", 32'(M_din_id), 32'd0);
        M0_req = 0; M1_req = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        q.push_back('{v: 1'b0, d: '0, id: 1'b0});
        step("post_rst", vecs[17]);

        // Illegal double select: slave0 data must win.
        force_both = 1'b1;
        step("both_sel", mk(1,0,8'h35,32'h0, 0,0,8'h00,32'h0, 1,8'h35,0,32'h0,
                            1,32'hC0DE0015,0));
        step("both_ret", vecs[17]);
        force_both = 1'b0;
        step("final", vecs[17]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
